// File: rtl/dspch_inst_queue.sv
// In-order dual-width instruction queue between decode and dispatch.
// Optional NOP_SQUASH_EN: valid nop bundles (bit 63) are dropped at enqueue instead of being stored.

module dspch_iq_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         we0,
  input  logic         we1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] q
);
  // Storage is intentionally not reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (we0)      q <= d0;
    else if (we1) q <= d1;
  end
endmodule

module dspch_inst_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [63:0]      in_inst1,
  input  logic [63:0]      in_inst2,
  output logic             in_ready,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic [63:0]      out_inst1,
  output logic [63:0]      out_inst2,
  input  logic [1:0]       dspch_cnt,
  output logic [PTR_W:0]   q_count
);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]            r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]            r_count;
  logic [DEPTH-1:0][63:0]      w_mem;
  logic [PTR_W-1:0]            w_wr_nxt1, w_rd_nxt1;
  logic                        w_fire, w_keep1, w_keep2;
  logic                        w_slot0_en, w_slot1_en;
  logic [63:0]                 w_wd0, w_wd1;
  logic [1:0]                  w_enq_n, w_req, w_deq_n;

  // Readiness looks only at the registered count, so a same-cycle dequeue never opens the gate.
  assign in_ready = (r_count <= CNT_W'(DEPTH - 2));
  assign w_fire   = in_ready & in_valid[0] & ~flush;

`ifdef NOP_SQUASH_EN
  assign w_keep1 = w_fire & ~in_inst1[63];
  assign w_keep2 = w_fire & in_valid[1] & ~in_inst2[63];
  assign w_wd0   = w_keep1 ? in_inst1 : in_inst2;
`else
  assign w_keep1 = w_fire;
  assign w_keep2 = w_fire & in_valid[1];
  assign w_wd0   = in_inst1;
`endif
  assign w_wd1 = in_inst2;

  // Surviving bundles are packed: slot0 at wr_ptr, slot1 at wr_ptr+1.
  assign w_slot0_en = w_keep1 | w_keep2;
  assign w_slot1_en = w_keep1 & w_keep2;
  assign w_enq_n    = {1'b0, w_keep1} + {1'b0, w_keep2};
  assign w_wr_nxt1  = r_wr_ptr + PTR_W'(1);
  assign w_rd_nxt1  = r_rd_ptr + PTR_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      dspch_iq_entry #(.W(64)) u_ent (
        .clk (clk),
        .we0 (w_slot0_en & (r_wr_ptr  == PTR_W'(gi))),
        .we1 (w_slot1_en & (w_wr_nxt1 == PTR_W'(gi))),
        .d0  (w_wd0),
        .d1  (w_wd1),
        .q   (w_mem[gi])
      );
    end
  endgenerate

  // A request of 3 means 2; requests beyond occupancy are clamped.
  always_comb begin
    w_req = (dspch_cnt == 2'd0) ? 2'd0 : (dspch_cnt == 2'd1) ? 2'd1 : 2'd2;
    w_deq_n = w_req;
    if (r_count < CNT_W'(w_req)) w_deq_n = r_count[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_enq_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq_n);
      r_count  <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq_n);
    end
  end

  assign out_valid1 = (r_count != '0);
  assign out_valid2 = (r_count >= CNT_W'(2));
  assign out_inst1  = out_valid1 ? w_mem[r_rd_ptr]  : '0;
  assign out_inst2  = out_valid2 ? w_mem[w_rd_nxt1] : '0;
  assign q_count    = r_count;
endmodule

// File: tb/tb_dspch_inst_queue.sv
// Directed bench for dspch_inst_queue (DEPTH=8); expectations hand-derived per step.
module tb_dspch_inst_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_inst1, in_inst2;
  logic        in_ready;
  logic        out_valid1, out_valid2;
  logic [63:0] out_inst1, out_inst2;
  logic [1:0]  dspch_cnt;
  logic [3:0]  q_count;

  int checks = 0;
  int errors = 0;

`ifdef NOP_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  dspch_inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_inst1(in_inst1), .in_inst2(in_inst2), .in_ready(in_ready),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_inst1(out_inst1), .out_inst2(out_inst2),
    .dspch_cnt(dspch_cnt), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bnd(input logic nop, input logic [31:0] pc);
    return {nop, 31'(pc * 3), pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] d);
    in_valid = v; in_inst1 = a; in_inst2 = b; dspch_cnt = d; flush = 1'b0;
  endtask

  task automatic idle();
    in_valid = 2'b00; dspch_cnt = 2'd0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_inst1 = '0; in_inst2 = '0;
    idle();
    #2;
    chk("rst_qcount", 64'(q_count), 64'd0);
    chk("rst_ready",  64'(in_ready), 64'd1);
    chk("rst_v1",     64'(out_valid1), 64'd0);
    chk("rst_inst1",  out_inst1, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // T2: first pair visible one cycle later
    drive(2'b11, bnd(0, 32'h100), bnd(0, 32'h104), 2'd0);
    step(); idle();
    chk("t2_v1",    64'(out_valid1), 64'd1);
    chk("t2_v2",    64'(out_valid2), 64'd1);
    chk("t2_inst1", out_inst1, bnd(0, 32'h100));
    chk("t2_inst2", out_inst2, bnd(0, 32'h104));
    chk("t2_count", 64'(q_count), 64'd2);

    // T3: fill to 7
    drive(2'b11, bnd(0, 32'h108), bnd(0, 32'h10c), 2'd0); step();
    drive(2'b11, bnd(0, 32'h110), bnd(0, 32'h114), 2'd0); step();
    chk("t3_ready6", 64'(in_ready), 64'd1);
    drive(2'b01, bnd(0, 32'h118), bnd(0, 32'h0), 2'd0); step();
    chk("t3_count7", 64'(q_count), 64'd7);
    chk("t3_ready7", 64'(in_ready), 64'd0);
    drive(2'b11, bnd(0, 32'h120), bnd(0, 32'h124), 2'd0); step();
    chk("t3_held", 64'(q_count), 64'd7);
    // dequeue frees room but the held pair still does not enter this cycle
    drive(2'b11, bnd(0, 32'h120), bnd(0, 32'h124), 2'd2); step();
    chk("t3_deq_count", 64'(q_count), 64'd5);
    chk("t3_ready_again", 64'(in_ready), 64'd1);
    chk("t3_head", out_inst1, bnd(0, 32'h108));
    drive(2'b11, bnd(0, 32'h120), bnd(0, 32'h124), 2'd0); step();
    chk("t3_refill", 64'(q_count), 64'd7);
    // rd=2: 108 10c 110 114 118 120 124, wr=1

    idle(); dspch_cnt = 2'd2; step();   // rd=4, count 5
    chk("t3_head2", out_inst1, bnd(0, 32'h110));
    dspch_cnt = 2'd2; step();           // rd=6, count 3
    chk("pre_t4_count", 64'(q_count), 64'd3);

    // T4: simultaneous enqueue 2 / dequeue 2
    drive(2'b11, bnd(0, 32'h130), bnd(0, 32'h134), 2'd2); step();
    chk("t4_count", 64'(q_count), 64'd3);
    chk("t4_inst1", out_inst1, bnd(0, 32'h124));
    chk("t4_inst2", out_inst2, bnd(0, 32'h130));

    // walk rd_ptr to 7 keeping count at 3
    drive(2'b11, bnd(0, 32'h140), bnd(0, 32'h144), 2'd2); step();
    drive(2'b11, bnd(0, 32'h150), bnd(0, 32'h154), 2'd2); step();
    drive(2'b11, bnd(0, 32'h160), bnd(0, 32'h164), 2'd2); step();
    drive(2'b01, bnd(0, 32'h168), bnd(0, 32'h0), 2'd1); step();
    chk("pre_t4b_inst1", out_inst1, bnd(0, 32'h160));
    chk("pre_t4b_inst2", out_inst2, bnd(0, 32'h164));

    // T4b: rd 7 -> 1 across wrap
    drive(2'b11, bnd(0, 32'h170), bnd(0, 32'h174), 2'd2); step();
    chk("t4b_count", 64'(q_count), 64'd3);
    chk("t4b_inst1", out_inst1, bnd(0, 32'h168));
    chk("t4b_inst2", out_inst2, bnd(0, 32'h170));

    // T5: drain and over-request
    idle(); dspch_cnt = 2'd2; step();
    chk("t5_count1", 64'(q_count), 64'd1);
    chk("t5_v2", 64'(out_valid2), 64'd0);
    chk("t5_inst2_zero", out_inst2, 64'd0);
    dspch_cnt = 2'd2; step();
    chk("t5_count0", 64'(q_count), 64'd0);
    chk("t5_v1", 64'(out_valid1), 64'd0);
    chk("t5_inst1_zero", out_inst1, 64'd0);
    dspch_cnt = 2'd3; step();
    chk("t5_no_underflow", 64'(q_count), 64'd0);

    // illegal in_valid=2'b10 writes nothing
    drive(2'b10, bnd(0, 32'h180), bnd(0, 32'h184), 2'd0); step();
    chk("v10_ignored", 64'(q_count), 64'd0);

    // T5b: flush overrides enqueue and dequeue
    drive(2'b11, bnd(0, 32'h190), bnd(0, 32'h194), 2'd0); step();
    drive(2'b11, bnd(0, 32'h198), bnd(0, 32'h19c), 2'd0); step();
    chk("t5b_count4", 64'(q_count), 64'd4);
    drive(2'b11, bnd(0, 32'h1a0), bnd(0, 32'h1a4), 2'd1); flush = 1'b1; step();
    idle();
    chk("t5b_flush_count", 64'(q_count), 64'd0);
    chk("t5b_flush_v1", 64'(out_valid1), 64'd0);
    drive(2'b11, bnd(0, 32'h1b0), bnd(0, 32'h1b4), 2'd0); step();
    chk("t5b_after_flush", out_inst1, bnd(0, 32'h1b0));
    idle(); dspch_cnt = 2'd2; step();   // empty, rd=wr=2

    // T6: nop in slot 1
    drive(2'b11, bnd(1, 32'h1fc), bnd(0, 32'h200), 2'd0); step();
    chk("t6_count", 64'(q_count), SQ ? 64'd1 : 64'd2);
    chk("t6_inst1", out_inst1, SQ ? bnd(0, 32'h200) : bnd(1, 32'h1fc));
    drive(2'b11, bnd(1, 32'h210), bnd(1, 32'h214), 2'd0); step();
    chk("t6_both_nop", 64'(q_count), SQ ? 64'd1 : 64'd4);

    // T1: asynchronous reset mid-run at count 5
    idle(); flush = 1'b1; step();
    drive(2'b11, bnd(0, 32'h300), bnd(0, 32'h304), 2'd0); step();
    drive(2'b11, bnd(0, 32'h308), bnd(0, 32'h30c), 2'd0); step();
    drive(2'b01, bnd(0, 32'h310), bnd(0, 32'h0), 2'd0); step();
    idle();
    chk("t1_count5", 64'(q_count), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_count", 64'(q_count), 64'd0);
    chk("t1_v1", 64'(out_valid1), 64'd0);
    chk("t1_v2", 64'(out_valid2), 64'd0);
    chk("t1_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
